// File: rtl/arm_decode_unit.sv
// -----------------------------------------------------------------------------
// arm_decode_unit
//
// Control decode for the single-cycle ARM datapath. The instruction word and
// its condition result are sampled on the rising clock edge and decoded into
// register-file addresses, write enables, operand-path mux selects and
// immediate fields (one cycle of latency). The write-back data for Rd, PC and
// CPSR is formed combinationally from those registered controls and the
// current ALU result, PC and CPSR.
//
// Decoded classes: data processing (immediate, immediate-shift and
// register-shift operand forms) and B/BL. Every other class is a no-op: all
// enables and selects are 0, and the address/immediate fields are still
// extracted from the word.
//
// There is no handshake and no stall: a new instruction may be presented on
// every cycle and its decode appears on the outputs one cycle later.
//
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   cond_pass                  condition field of inst evaluated true
//   inst                       instruction word
//   rn_out, rm_out, rs_out     register-file read data (not needed here)
//   pc_out                     current PC (instruction address + 8)
//   cpsr_out                   current CPSR
//   alu_out                    ALU result
//   read_rn/rm/rs, write_rd    register-file addresses
//   rd_we, pc_we, cpsr_we      write enables (gated by cond_pass)
//   rd_in, pc_in, cpsr_in      write-back data
//   shiftee_sel                00 rm_out, 01 immed_8, 10 immed_32
//   immed_8_shiftee_in         8-bit immediate
//   immed_32_shiftee_in        32-bit immediate
//   shifter_sel                00 shift_imm, 01 rs_out[7:0], 10 2*rotate_imm
//   rotate_imm_shifter_in      rotate field
//   shift_imm_shifter_in       shift amount
//   barrel_sel                 {rot-imm form, reg shift, shift type[1:0]}
//   alu_sel                    ALU opcode (ARM data-processing encoding)
// -----------------------------------------------------------------------------
module arm_decode_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cond_pass,
   input  logic [31:0] inst,
   input  logic [31:0] rn_out,
   input  logic [31:0] rm_out,
   input  logic [31:0] rs_out,
   input  logic [31:0] pc_out,
   input  logic [31:0] cpsr_out,
   input  logic [31:0] alu_out,
   output logic [3:0]  read_rn,
   output logic [3:0]  read_rm,
   output logic [3:0]  read_rs,
   output logic [3:0]  write_rd,
   output logic        rd_we,
   output logic        pc_we,
   output logic        cpsr_we,
   output logic [31:0] rd_in,
   output logic [31:0] pc_in,
   output logic [31:0] cpsr_in,
   output logic [1:0]  shiftee_sel,
   output logic [7:0]  immed_8_shiftee_in,
   output logic [31:0] immed_32_shiftee_in,
   output logic [1:0]  shifter_sel,
   output logic [3:0]  rotate_imm_shifter_in,
   output logic [4:0]  shift_imm_shifter_in,
   output logic [3:0]  barrel_sel,
   output logic [3:0]  alu_sel
);

   // Instruction class detection
   logic is_branch;
   logic is_dp_imm;
   logic is_dp_reg;
   logic is_test_op;

   assign is_branch  = (inst[27:25] == 3'b101);
   assign is_dp_imm  = (inst[27:25] == 3'b001);
   // Register-operand data processing; bit7 & bit4 both set is the
   // multiply / extra load-store space, which is treated as a no-op.
   assign is_dp_reg  = (inst[27:25] == 3'b000) && !(inst[7] && inst[4]);
   // TST/TEQ/CMP/CMN are opcodes 8..B: only the flags are written.
   assign is_test_op = (inst[24:23] == 2'b10);

   // Next-state decode
   logic [3:0]  nx_read_rn;
   logic [3:0]  nx_write_rd;
   logic        nx_rd_we;
   logic        nx_pc_we;
   logic        nx_cpsr_we;
   logic        nx_link;
   logic [1:0]  nx_shiftee_sel;
   logic [31:0] nx_immed_32;
   logic [1:0]  nx_shifter_sel;
   logic [4:0]  nx_shift_imm;
   logic [3:0]  nx_barrel_sel;
   logic [3:0]  nx_alu_sel;

   always_comb begin
      nx_read_rn     = inst[19:16];
      nx_write_rd    = inst[15:12];
      nx_rd_we       = 1'b0;
      nx_pc_we       = 1'b0;
      nx_cpsr_we     = 1'b0;
      nx_link        = 1'b0;
      nx_shiftee_sel = 2'b00;
      nx_immed_32    = {24'b0, inst[7:0]};
      nx_shifter_sel = 2'b00;
      nx_shift_imm   = inst[11:7];
      nx_barrel_sel  = 4'b0000;
      nx_alu_sel     = 4'b0000;

      if (is_branch) begin
         // Target = PC + (sign-extended offset << 2), computed by the ALU
         // as rn(=PC) + shiftee(immed_32) LSL 2.
         nx_read_rn     = 4'd15;
         nx_immed_32    = {{8{inst[23]}}, inst[23:0]};
         nx_shiftee_sel = 2'b10;
         nx_shift_imm   = 5'd2;
         nx_alu_sel     = 4'd4;
         nx_pc_we       = 1'b1;
         if (inst[24]) begin
            nx_write_rd = 4'd14;
            nx_rd_we    = 1'b1;
            nx_link     = 1'b1;
         end
      end else if (is_dp_imm || is_dp_reg) begin
         nx_alu_sel = inst[24:21];
         if (is_dp_imm) begin
            nx_shiftee_sel = 2'b01;
            nx_shifter_sel = 2'b10;
            nx_barrel_sel  = 4'b1011;
         end else if (!inst[4]) begin
            nx_barrel_sel  = {2'b00, inst[6:5]};
         end else begin
            nx_shifter_sel = 2'b01;
            nx_barrel_sel  = {2'b01, inst[6:5]};
         end
         if (!is_test_op) begin
            if (inst[15:12] == 4'd15) begin
               nx_pc_we = 1'b1;
            end else begin
               nx_rd_we = 1'b1;
            end
         end
         nx_cpsr_we = inst[20];
      end

      // A failed condition still decodes every field but commits nothing.
      if (!cond_pass) begin
         nx_rd_we   = 1'b0;
         nx_pc_we   = 1'b0;
         nx_cpsr_we = 1'b0;
      end
   end

   // Registered controls
   logic link_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         read_rn               <= 4'd0;
         read_rm               <= 4'd0;
         read_rs               <= 4'd0;
         write_rd              <= 4'd0;
         rd_we                 <= 1'b0;
         pc_we                 <= 1'b0;
         cpsr_we               <= 1'b0;
         link_q                <= 1'b0;
         shiftee_sel           <= 2'b00;
         immed_8_shiftee_in    <= 8'd0;
         immed_32_shiftee_in   <= 32'd0;
         shifter_sel           <= 2'b00;
         rotate_imm_shifter_in <= 4'd0;
         shift_imm_shifter_in  <= 5'd0;
         barrel_sel            <= 4'd0;
         alu_sel               <= 4'd0;
      end else begin
         read_rn               <= nx_read_rn;
         read_rm               <= inst[3:0];
         read_rs               <= inst[11:8];
         write_rd              <= nx_write_rd;
         rd_we                 <= nx_rd_we;
         pc_we                 <= nx_pc_we;
         cpsr_we               <= nx_cpsr_we;
         link_q                <= nx_link;
         shiftee_sel           <= nx_shiftee_sel;
         immed_8_shiftee_in    <= inst[7:0];
         immed_32_shiftee_in   <= nx_immed_32;
         shifter_sel           <= nx_shifter_sel;
         rotate_imm_shifter_in <= inst[11:8];
         shift_imm_shifter_in  <= nx_shift_imm;
         barrel_sel            <= nx_barrel_sel;
         alu_sel               <= nx_alu_sel;
      end
   end

   // Write-back data. pc_out is the instruction address + 8, so the BL
   // return address (next instruction) is pc_out - 4.
   assign rd_in   = link_q ? (pc_out - 32'd4) : alu_out;
   assign pc_in   = alu_out;
   // N and Z from the result; C and V are carried over unchanged.
   assign cpsr_in = {alu_out[31], (alu_out == 32'd0), cpsr_out[29:0]};

   // Register read data and the condition nibble are consumed elsewhere.
   logic unused_inputs;
   assign unused_inputs = ^{rn_out, rm_out, rs_out, cpsr_out[31:30], inst[31:28]};

endmodule

// File: tb/tb_arm_decode_unit.sv
// -----------------------------------------------------------------------------
// tb_arm_decode_unit
//
// Directed cases for the documented instruction examples, then randomized
// instructions checked field-by-field against a behavioural decode model.
// -----------------------------------------------------------------------------
module tb_arm_decode_unit;

   // Clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT signals
   logic        cond_pass = 1'b0;
   logic [31:0] inst = 32'd0;
   logic [31:0] rn_out = 32'd0, rm_out = 32'd0, rs_out = 32'd0;
   logic [31:0] pc_out = 32'd0, cpsr_out = 32'd0, alu_out = 32'd0;
   logic [3:0]  read_rn, read_rm, read_rs, write_rd;
   logic        rd_we, pc_we, cpsr_we;
   logic [31:0] rd_in, pc_in, cpsr_in;
   logic [1:0]  shiftee_sel, shifter_sel;
   logic [7:0]  immed_8_shiftee_in;
   logic [31:0] immed_32_shiftee_in;
   logic [3:0]  rotate_imm_shifter_in;
   logic [4:0]  shift_imm_shifter_in;
   logic [3:0]  barrel_sel, alu_sel;

   arm_decode_unit dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .cond_pass             (cond_pass),
      .inst                  (inst),
      .rn_out                (rn_out),
      .rm_out                (rm_out),
      .rs_out                (rs_out),
      .pc_out                (pc_out),
      .cpsr_out              (cpsr_out),
      .alu_out               (alu_out),
      .read_rn               (read_rn),
      .read_rm               (read_rm),
      .read_rs               (read_rs),
      .write_rd              (write_rd),
      .rd_we                 (rd_we),
      .pc_we                 (pc_we),
      .cpsr_we               (cpsr_we),
      .rd_in                 (rd_in),
      .pc_in                 (pc_in),
      .cpsr_in               (cpsr_in),
      .shiftee_sel           (shiftee_sel),
      .immed_8_shiftee_in    (immed_8_shiftee_in),
      .immed_32_shiftee_in   (immed_32_shiftee_in),
      .shifter_sel           (shifter_sel),
      .rotate_imm_shifter_in (rotate_imm_shifter_in),
      .shift_imm_shifter_in  (shift_imm_shifter_in),
      .barrel_sel            (barrel_sel),
      .alu_sel               (alu_sel)
   );

   // Expected decode of one instruction
   typedef struct packed {
      logic [3:0]  rn, rm, rs, rd;
      logic        rd_we, pc_we, cpsr_we, link;
      logic [1:0]  shiftee, shifter;
      logic [7:0]  imm8;
      logic [31:0] imm32;
      logic [3:0]  rot;
      logic [4:0]  shamt;
      logic [3:0]  barrel, alu;
   } exp_t;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (inst %08h)", tag, got, exp, inst);
      end
   endtask

   // Behavioural model: classify the word, then apply the class rules.
   function automatic exp_t model(input logic [31:0] i, input logic cp);
      exp_t e;
      int   opc;
      bit   commit;
      e       = '0;
      e.rn    = i[19:16];
      e.rm    = i[3:0];
      e.rs    = i[11:8];
      e.rd    = i[15:12];
      e.imm8  = i[7:0];
      e.rot   = i[11:8];
      e.shamt = i[11:7];
      e.imm32 = 32'(i[7:0]);
      opc     = int'(i[24:21]);
      commit  = cp;
      if (i[27:25] == 3'b101) begin
         e.rn      = 4'd15;
         e.imm32   = 32'($signed(i[23:0]));
         e.shiftee = 2'd2;
         e.shamt   = 5'd2;
         e.alu     = 4'd4;
         e.pc_we   = commit;
         if (i[24]) begin
            e.rd    = 4'd14;
            e.rd_we = commit;
            e.link  = 1'b1;
         end
      end else if (i[27:25] == 3'b001 || (i[27:25] == 3'b000 && !(i[7] && i[4]))) begin
         e.alu = 4'(opc);
         if (i[25]) begin
            e.shiftee = 2'd1;
            e.shifter = 2'd2;
            e.barrel  = 4'd11;
         end else if (i[4]) begin
            e.shifter = 2'd1;
            e.barrel  = 4'(4 + int'(i[6:5]));
         end else begin
            e.barrel  = 4'(int'(i[6:5]));
         end
         if (opc < 8 || opc > 11) begin
            if (int'(i[15:12]) == 15) e.pc_we = commit;
            else                      e.rd_we = commit;
         end
         e.cpsr_we = commit && i[20];
      end
      return e;
   endfunction

   task automatic check_model(input exp_t e);
      check("read_rn", 32'(read_rn), 32'(e.rn));
      check("read_rm", 32'(read_rm), 32'(e.rm));
      check("read_rs", 32'(read_rs), 32'(e.rs));
      check("write_rd", 32'(write_rd), 32'(e.rd));
      check("rd_we", 32'(rd_we), 32'(e.rd_we));
      check("pc_we", 32'(pc_we), 32'(e.pc_we));
      check("cpsr_we", 32'(cpsr_we), 32'(e.cpsr_we));
      check("shiftee_sel", 32'(shiftee_sel), 32'(e.shiftee));
      check("shifter_sel", 32'(shifter_sel), 32'(e.shifter));
      check("immed_8", 32'(immed_8_shiftee_in), 32'(e.imm8));
      check("immed_32", immed_32_shiftee_in, e.imm32);
      check("rotate_imm", 32'(rotate_imm_shifter_in), 32'(e.rot));
      check("shift_imm", 32'(shift_imm_shifter_in), 32'(e.shamt));
      check("barrel_sel", 32'(barrel_sel), 32'(e.barrel));
      check("alu_sel", 32'(alu_sel), 32'(e.alu));
      check("rd_in", rd_in, e.link ? pc_out - 32'd4 : alu_out);
      check("pc_in", pc_in, alu_out);
      check("cpsr_in", cpsr_in, {alu_out[31], alu_out == 32'd0, cpsr_out[29:0]});
   endtask

   task automatic check_reset_state();
      check("rst_we", {29'd0, rd_we, pc_we, cpsr_we}, 32'd0);
      check("rst_addr", {16'd0, read_rn, read_rm, read_rs, write_rd}, 32'd0);
      check("rst_sel", {20'd0, shiftee_sel, shifter_sel, barrel_sel, alu_sel}, 32'd0);
      check("rst_imm", {15'd0, immed_8_shiftee_in, rotate_imm_shifter_in, shift_imm_shifter_in}, 32'd0);
      check("rst_imm32", immed_32_shiftee_in, 32'd0);
   endtask

   // Driver: present one instruction, let it be sampled, then set the
   // datapath inputs and leave time for the combinational write-back data.
   exp_t cur;

   task automatic apply(input logic [31:0] i, input logic cp,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic [31:0] cpsr);
      @(negedge clk);
      inst      = i;
      cond_pass = cp;
      @(posedge clk);
      #1;
      alu_out  = alu;
      pc_out   = pc;
      cpsr_out = cpsr;
      #1;
      cur = model(i, cp);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] i;
      i = $urandom;
      case ($urandom_range(0, 5))
         0: i[27:25] = 3'b001;
         1: begin i[27:25] = 3'b000; i[7] = 1'b0; end
         2: begin i[27:25] = 3'b000; i[4] = 1'b0; end
         3: i[27:25] = 3'b101;
         4: i[27:26] = 2'b01;
         default: ;
      endcase
      return i;
   endfunction

   initial begin
      // Reset held two cycles with a valid instruction present
      rst_n     = 1'b0;
      inst      = 32'hE0834002;
      cond_pass = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state();
      @(negedge clk);
      rst_n = 1'b1;

      // AND R1,R1,#2
      apply(32'hE2011002, 1'b1, 32'h00000002, 32'h00000100, 32'h00000000);
      check("and_alu", 32'(alu_sel), 32'h0);
      check("and_shiftee", 32'(shiftee_sel), 32'h1);
      check("and_shifter", 32'(shifter_sel), 32'h2);
      check("and_barrel", 32'(barrel_sel), 32'hB);
      check("and_rn_rd", {24'd0, read_rn, write_rd}, 32'h11);
      check("and_imm8", 32'(immed_8_shiftee_in), 32'h02);
      check("and_rot", 32'(rotate_imm_shifter_in), 32'h0);
      check("and_rd_we", 32'(rd_we), 32'h1);
      check_model(cur);

      // BIC R9,R8,#0xFF00
      apply(32'hE3C89CFF, 1'b1, 32'h12345678, 32'h00000104, 32'h20000000);
      check("bic_alu", 32'(alu_sel), 32'hE);
      check("bic_rn_rd", {24'd0, read_rn, write_rd}, 32'h89);
      check("bic_imm8", 32'(immed_8_shiftee_in), 32'hFF);
      check("bic_rot", 32'(rotate_imm_shifter_in), 32'hC);
      check_model(cur);

      // CMP R7,R8 with a zero result
      apply(32'hE1570008, 1'b1, 32'h00000000, 32'h00000108, 32'h00000000);
      check("cmp_alu", 32'(alu_sel), 32'hA);
      check("cmp_rn_rm", {24'd0, read_rn, read_rm}, 32'h78);
      check("cmp_we", {29'd0, rd_we, pc_we, cpsr_we}, 32'h1);
      check("cmp_cpsr_in", cpsr_in, 32'h40000000);
      check_model(cur);

      // ADD R9,R5,R5,LSL #3
      apply(32'hE0859185, 1'b1, 32'h00000028, 32'h0000010C, 32'h00000000);
      check("add_lsl_shamt", 32'(shift_imm_shifter_in), 32'd3);
      check("add_lsl_barrel", 32'(barrel_sel), 32'h0);
      check("add_lsl_shifter", 32'(shifter_sel), 32'h0);
      check_model(cur);

      // SUB R10,R9,R8,LSR #4
      apply(32'hE049A228, 1'b1, 32'hFFFFFFF0, 32'h00000110, 32'h30000000);
      check("sub_lsr_alu", 32'(alu_sel), 32'h2);
      check("sub_lsr_barrel", 32'(barrel_sel), 32'h1);
      check("sub_lsr_shamt", 32'(shift_imm_shifter_in), 32'd4);
      check_model(cur);

      // MOV R12,R4,ROR R3
      apply(32'hE1A0C374, 1'b1, 32'h80000001, 32'h00000114, 32'h00000000);
      check("mov_ror_alu", 32'(alu_sel), 32'hD);
      check("mov_ror_rd", 32'(write_rd), 32'hC);
      check("mov_ror_rm_rs", {24'd0, read_rm, read_rs}, 32'h43);
      check("mov_ror_shifter", 32'(shifter_sel), 32'h1);
      check("mov_ror_barrel", 32'(barrel_sel), 32'h7);
      check_model(cur);

      // BL +0x0A
      apply(32'hEB00000A, 1'b1, 32'h00000128, 32'h00000100, 32'h00000000);
      check("bl_rn_rd", {24'd0, read_rn, write_rd}, 32'hFE);
      check("bl_imm32", immed_32_shiftee_in, 32'h0000000A);
      check("bl_shamt", 32'(shift_imm_shifter_in), 32'd2);
      check("bl_shiftee", 32'(shiftee_sel), 32'h2);
      check("bl_alu", 32'(alu_sel), 32'h4);
      check("bl_we", {30'd0, rd_we, pc_we}, 32'h3);
      check("bl_rd_in", rd_in, 32'h000000FC);
      check("bl_pc_in", pc_in, 32'h00000128);
      check_model(cur);

      // Condition failed: ADD R4,R3,R2
      apply(32'hE0834002, 1'b0, 32'h00000005, 32'h00000100, 32'h00000000);
      check("nocond_we", {29'd0, rd_we, pc_we, cpsr_we}, 32'h0);
      check("nocond_alu", 32'(alu_sel), 32'h4);
      check("nocond_rn", 32'(read_rn), 32'h3);
      check_model(cur);

      // LDR word: no-op
      apply(32'hE5912000, 1'b1, 32'h00000005, 32'h00000100, 32'h00000000);
      check("ldr_we", {29'd0, rd_we, pc_we, cpsr_we}, 32'h0);
      check("ldr_sel", {22'd0, shiftee_sel, shifter_sel, barrel_sel, alu_sel}, 32'h0);
      check_model(cur);

      // Randomized instructions, with an occasional reset pulse
      for (int n = 0; n < 400; n++) begin
         if (n % 50 == 49) begin
            @(negedge clk);
            rst_n     = 1'b0;
            inst      = rand_inst();
            cond_pass = 1'b1;
            @(posedge clk);
            #1;
            check_reset_state();
            @(negedge clk);
            rst_n = 1'b1;
         end
         apply(rand_inst(), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
               $urandom, $urandom);
         check_model(cur);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/arm_decode_unit.md
# arm_decode_unit

Control decode unit for the single-cycle ARM datapath. Samples the current instruction word and its condition result, then produces register-file read/write addresses and write enables, operand-path mux selects, and immediate fields for the shiftee mux, shifter mux, barrel shifter and ALU. It also forms the write-back data for Rd, PC and CPSR from the ALU result and the register-file outputs. Scope: data-processing and B/BL instructions; every other instruction class decodes as a no-op.

## Interface
Parameters: none.

Clocking: one clock; reset is synchronous and active-low.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cond_pass  in  1  condition field of inst evaluated true against CPSR
- inst  in  32  instruction word
- rn_out, rm_out, rs_out  in  32 each  register-file read data
- pc_out  in  32  current PC (instruction address + 8)
- cpsr_out  in  32  current CPSR
- alu_out  in  32  ALU result
- read_rn, read_rm, read_rs  out  4 each  register-file read addresses
- write_rd  out  4  register-file write address
- rd_we, pc_we, cpsr_we  out  1 each  write enables
- rd_in, pc_in, cpsr_in  out  32 each  write-back data
- shiftee_sel  out  2  shiftee source: 00 = rm_out, 01 = immed_8 zero-extended, 10 = immed_32, 11 = reserved (treat as 00)
- immed_8_shiftee_in  out  8  8-bit immediate
- immed_32_shiftee_in  out  32  32-bit immediate
- shifter_sel  out  2  shift-amount source: 00 = shift_imm, 01 = rs_out[7:0], 10 = 2 × rotate_imm, 11 = zero
- rotate_imm_shifter_in  out  4  rotate field
- shift_imm_shifter_in  out  5  shift amount
- barrel_sel  out  4  bit 3 = rotated-immediate form, bit 2 = register-specified shift, bits [1:0] = shift type (00 LSL, 01 LSR, 10 ASR, 11 ROR)
- alu_sel  out  4  ALU opcode, using the ARM data-processing encoding

## Operation
Field extraction, applied to every instruction:
- read_rn = inst[19:16]
- read_rm = inst[3:0]
- read_rs = inst[11:8]
- write_rd = inst[15:12]
- immed_8 = inst[7:0]
- rotate_imm = inst[11:8]
- shift_imm = inst[11:7]
- immed_32 = {24'b0, inst[7:0]}
- alu_sel = inst[24:21]

Data processing (inst[27:26] = 00):
- Immediate form (inst[25] = 1): shiftee 01, shifter 10, barrel 4'b1011.
- Immediate shift (inst[25] = 0, inst[4] = 0): shiftee 00, shifter 00, barrel {2'b00, inst[6:5]}.
- Register shift (inst[25] = 0, inst[4] = 1, inst[7] = 0): shiftee 00, shifter 01, barrel {2'b01, inst[6:5]}.
- Test opcodes TST, TEQ, CMP, CMN (alu_sel 8 to B): no Rd or PC write.
- Other opcodes with Rd ≠ 15: rd_we = 1, rd_in = alu_out.
- Other opcodes with Rd = 15: pc_we = 1, pc_in = alu_out, rd_we = 0.
- S bit (inst[20]) set: cpsr_we = 1. cpsr_in = {alu_out[31], alu_out == 0, cpsr_out[29:0]}, so C and V are preserved.

Branch (inst[27:25] = 101):
- read_rn = 15
- immed_32 = sign-extend(inst[23:0])
- shiftee 10, shifter 00, shift_imm = 2, barrel 0000, alu_sel = 4 (ADD)
- pc_we = 1, pc_in = alu_out
- BL (inst[24] = 1) also sets write_rd = 14, rd_we = 1, rd_in = pc_out − 4.

Other classes:
- Load/store, multiply, and any inst[7] = 1 ∧ inst[4] = 1 pattern are no-ops.
- All enables are 0 and all selects are 0; address fields follow the extraction rules above.

cond_pass = 0 forces rd_we, pc_we and cpsr_we to 0. Selects and fields still decode normally.

## Timing
- inst and cond_pass are sampled on rising clk. All decoded outputs are registered, giving latency 1 cycle.
- rd_in, pc_in and cpsr_in are combinational from the registered controls and the current alu_out, pc_out and cpsr_out. They settle within the same cycle the controls are valid.
- Reset: when rst_n = 0 at a rising edge, every registered output becomes 0 on the next cycle; in particular rd_we = pc_we = cpsr_we = 0.
- Reset asserted mid-instruction discards that decode. The first valid decode appears 1 cycle after the first edge with rst_n = 1.
- inst changing every cycle is fully supported; there is no handshake or stall.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with inst = E0834002 → all outputs 0, all enables 0.
- AND R1,R1,#2 (E2011002), cond_pass = 1 → alu_sel 0, shiftee 01, shifter 10, barrel B, read_rn 1, write_rd 1, immed_8 02, rotate 0, rd_we 1. Then BIC R9,R8,#0xFF00 (E3C89CFF) → alu_sel E, read_rn 8, write_rd 9, immed_8 FF, rotate C.
- CMP R7,R8 (E1570008) → alu_sel A, read_rn 7, read_rm 8, rd_we 0, pc_we 0, cpsr_we 1. With alu_out = 0 and cpsr_out = 0 → cpsr_in = 40000000.
- Shifted operands:
  - ADD R9,R5,R5,LSL #3 (E0859185) → shift_imm 3, barrel 0, shifter 00.
  - SUB R10,R9,R8,LSR #4 (E049A228) → alu_sel 2, barrel 1, shift_imm 4.
  - MOV R12,R4,ROR R3 (E1A0C374) → alu_sel D, write_rd C, read_rm 4, read_rs 3, shifter 01, barrel 7.
- BL (EB00000A) with pc_out = 00000100 → read_rn F, write_rd E, immed_32 0000000A, shift_imm 2, shiftee 10, alu_sel 4, rd_we 1, pc_we 1, rd_in 000000FC. With alu_out = 00000128 → pc_in 00000128.
- cond_pass = 0 with ADD R4,R3,R2 (E0834002) → enables all 0, alu_sel 4, read_rn 3. Then an LDR word (E5912000) → no-op, enables 0.
